// File: rtl/motion_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : motion_scheduler
//  Description : Decodes w/a/s/d/space key codes into a single one-hot motion
//                command, holds it for HOLD_TICKS timebase ticks, inserts a
//                DEAD_TICKS all-off gap between differing commands and aborts
//                when the active direction's enable drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module motion_scheduler #(
    parameter int HOLD_TICKS = 50,
    parameter int DEAD_TICKS = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       key_valid,
    input  logic       tick,
    input  logic       en_left,
    input  logic       en_right,
    input  logic       en_forward,
    input  logic       en_backward,
    output logic [1:0] rotate_sig,
    output logic [1:0] move_sig,
    output logic       rejected,
    output logic [1:0] state
);

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_run  = 2'd1;
    localparam logic [1:0]       c_st_dead = 2'd2;
    localparam logic [CNT_W-1:0] c_hold    = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] c_dead    = CNT_W'(DEAD_TICKS);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    // Command encoding is one-hot {left, right, forward, backward}
    logic [3:0]       w_en;
    logic [3:0]       w_key_cmd;
    logic             w_key_stop;
    logic             w_motion;
    logic             w_stop;
    logic             w_key_en;
    logic             w_accept;
    logic             w_reject;
    logic             w_tick_eff;
    logic             w_cmd_en;
    logic             w_pend_en;

    logic [3:0]       r_cmd;
    logic [3:0]       r_pending;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_state_nx;
    logic [3:0]       w_cmd_nx;
    logic [3:0]       w_pending_nx;
    logic [CNT_W-1:0] w_cnt_nx;

    assign w_en = {en_left, en_right, en_forward, en_backward};

    // Translate the ASCII code into a one-hot command or a STOP flag
    always_comb begin
        w_key_cmd  = 4'b0000;
        w_key_stop = 1'b0;
        case (key)
            8'h61:   w_key_cmd  = 4'b1000;
            8'h64:   w_key_cmd  = 4'b0100;
            8'h77:   w_key_cmd  = 4'b0010;
            8'h73:   w_key_cmd  = 4'b0001;
            8'h20:   w_key_stop = 1'b1;
            default: w_key_cmd  = 4'b0000;
        endcase
    end

    assign w_motion   = key_valid & (|w_key_cmd);
    assign w_stop     = key_valid & w_key_stop;
    assign w_key_en   = |(w_key_cmd & w_en);
    assign w_accept   = w_motion & w_key_en;
    assign w_reject   = w_motion & ~w_key_en;
    // A recognised key (even a refused one) consumes a coincident tick
    assign w_tick_eff = tick & ~(w_motion | w_stop);
    assign w_cmd_en   = |(r_cmd & w_en);
    assign w_pend_en  = |(r_pending & w_en);

    // Next-state decision for the IDLE / RUN / DEAD sequencer
    always_comb begin
        w_state_nx   = state;
        w_cmd_nx     = r_cmd;
        w_pending_nx = r_pending;
        w_cnt_nx     = r_cnt;
        case (state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nx = c_st_run;
                    w_cmd_nx   = w_key_cmd;
                    w_cnt_nx   = c_hold;
                end
            end
            c_st_run: begin
                if (!w_cmd_en || w_stop) begin
                    // Enable loss beats any key arriving in the same cycle
                    w_state_nx = c_st_idle;
                    w_cmd_nx   = 4'b0000;
                    w_cnt_nx   = '0;
                end else if (w_accept) begin
                    if (w_key_cmd == r_cmd) begin
                        w_cnt_nx = c_hold;
                    end else begin
                        w_state_nx   = c_st_dead;
                        w_cmd_nx     = 4'b0000;
                        w_pending_nx = w_key_cmd;
                        w_cnt_nx     = c_dead;
                    end
                end else if (w_tick_eff) begin
                    if (r_cnt == c_one) begin
                        w_state_nx = c_st_idle;
                        w_cmd_nx   = 4'b0000;
                        w_cnt_nx   = '0;
                    end else if (r_cnt != '0) begin
                        w_cnt_nx = r_cnt - c_one;
                    end
                end
            end
            c_st_dead: begin
                if (w_stop) begin
                    w_state_nx   = c_st_idle;
                    w_pending_nx = 4'b0000;
                    w_cnt_nx     = '0;
                end else if (w_accept) begin
                    // Latest key wins, but the gap is not lengthened
                    w_pending_nx = w_key_cmd;
                end else if (w_tick_eff) begin
                    if (r_cnt == c_one) begin
                        w_state_nx   = w_pend_en ? c_st_run : c_st_idle;
                        w_cmd_nx     = w_pend_en ? r_pending : 4'b0000;
                        w_cnt_nx     = w_pend_en ? c_hold : '0;
                        w_pending_nx = 4'b0000;
                    end else if (r_cnt != '0) begin
                        w_cnt_nx = r_cnt - c_one;
                    end
                end
            end
            default: begin
                w_state_nx   = c_st_idle;
                w_cmd_nx     = 4'b0000;
                w_pending_nx = 4'b0000;
                w_cnt_nx     = '0;
            end
        endcase
    end

    // Register sequencer state and drive outputs from the next command
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= c_st_idle;
            r_cmd      <= 4'b0000;
            r_pending  <= 4'b0000;
            r_cnt      <= '0;
            rotate_sig <= 2'b00;
            move_sig   <= 2'b00;
            rejected   <= 1'b0;
        end else begin
            state      <= w_state_nx;
            r_cmd      <= w_cmd_nx;
            r_pending  <= w_pending_nx;
            r_cnt      <= w_cnt_nx;
            rotate_sig <= w_cmd_nx[3:2];
            move_sig   <= w_cmd_nx[1:0];
            rejected   <= w_reject;
        end
    end

endmodule
`default_nettype wire

// File: doc/motion_scheduler.md
Name: motion_scheduler

Overview:
Sequences the robot's motion outputs from the keyboard byte stream. It decodes w/a/s/d/space keys into one active motion command and holds that command for a programmable number of ticks. It inserts a dead-time gap whenever the command changes, and aborts on loss of the per-direction enables. It sits between the keyboard receiver and the motor drivers, and replaces unclocked key-to-signal decoding with a registered, timed sequence.

Parameters:
HOLD_TICKS, 50, ticks a command stays active after its last accepting key (must be >= 1)
DEAD_TICKS, 4, ticks with all outputs low between two different commands (must be >= 1)
CNT_W, 8, width of the shared tick counter (must hold max(HOLD_TICKS, DEAD_TICKS))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key  in  8  ASCII key code from the keyboard receiver
key_valid  in  1  one-cycle strobe; key is valid this cycle
tick  in  1  one-cycle timebase strobe (nominally 1 kHz)
en_left  in  1  permits rotate left
en_right  in  1  permits rotate right
en_forward  in  1  permits move forward
en_backward  in  1  permits move backward
rotate_sig  out  2  [1]=left, [0]=right; registered
move_sig  out  2  [1]=forward, [0]=backward; registered
rejected  out  1  one-cycle pulse: motion key refused because its enable is low
state  out  2  0=IDLE, 1=RUN, 2=DEAD

Behaviour:
- Key decode: 8'h77 w -> forward; 8'h73 s -> backward; 8'h61 a -> left; 8'h64 d -> right; 8'h20 space -> STOP. Every other code is ignored: no state change, no rejected pulse.
- Command encoding: 4-bit one-hot {left,right,forward,backward}. At most one output bit is ever high.
- All outputs are registered. They change on the clk edge after the causing event (1-cycle latency).
- Reset: state=IDLE, cmd=0, pending=0, counter=0, rotate_sig=0, move_sig=0, rejected=0. Reset mid-RUN or mid-DEAD behaves the same way; outputs are 0 after the next edge.
- A motion key "accepted" means its enable is high in the cycle key_valid is high. If the enable is low, pulse rejected and leave the state unchanged.
- IDLE: outputs 0.
  - Accepted motion key -> RUN, cmd=key, counter=HOLD_TICKS.
  - STOP -> stay IDLE.
- RUN: output bit of cmd is high.
  - Same key accepted -> refresh counter=HOLD_TICKS. Output has no glitch.
  - Different motion key accepted -> DEAD, pending=key, counter=DEAD_TICKS, outputs 0.
  - STOP -> IDLE.
  - Enable of cmd's direction low -> IDLE, cmd=0. Enable-drop abort has priority over a key arriving in the same cycle.
  - tick with counter==1 -> IDLE. Otherwise tick decrements the counter.
- DEAD: outputs 0.
  - Accepted motion key -> replaces pending. The counter is not restarted.
  - STOP -> IDLE, pending=0.
  - tick with counter==1 -> RUN with cmd=pending, counter=HOLD_TICKS, but only if pending's enable is high at that cycle; otherwise -> IDLE.
  - Otherwise tick decrements the counter.
- key_valid and tick in the same cycle: the key action wins and that tick is discarded. This applies in every state.
- Counter never wraps. It is only decremented when >= 1.

Test Plan:
- Reset, all enables 1; key 8'h77 then 3 ticks, HOLD_TICKS=3 -> move_sig=2'b10 one cycle after key_valid; state=RUN; move_sig returns to 00 and state=IDLE the cycle after the 3rd tick.
- RUN forward, resend 8'h77 after 2 ticks (HOLD_TICKS=3) -> counter reloads; move_sig stays 10 continuously for 3 more ticks, with no 0 cycle.
- RUN forward, key 8'h73, DEAD_TICKS=4 -> move_sig=00 and state=DEAD for exactly 4 ticks, then move_sig=01 and state=RUN.
- en_left=0, key 8'h61 in IDLE -> rejected=1 for one cycle, rotate_sig stays 00, state stays IDLE. During RUN right, drop en_right -> rotate_sig=00 and state=IDLE next cycle.
- DEAD pending 's', key 8'h61 mid-gap, then space before expiry -> pending becomes left; space sends state to IDLE; all outputs stay 0.
- key_valid (8'h77 refresh) coincident with the tick at counter==1 -> key wins; state stays RUN with counter=HOLD_TICKS. Also assert rst mid-RUN -> outputs 0 and state=IDLE next edge.
